div_sequencer: RTL and testbench

Iterative divide controller for the EX stage of the pipelined RV32 core. It executes DIV/DIVU/REM/REMU with a radix-2 restoring algorithm and holds the front of the pipeline with a stall request until the result is ready. It works alongside the hazard unit. Its stall request is ORed into stall_F/stall_DE/stall_EX upstream, and the hazard unit's flush_EX aborts it. Its result joins the EX result mux.

---
 rtl/div_sequencer_pkg.sv | 28 ++
 rtl/div_restoring_step.sv | 34 +++
 rtl/div_sequencer.sv | 171 +++++++++++++++++
 tb/tb_div_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the EX-stage iterative divider.
//   div_state_t : sequencer state encoding (IDLE, CALC, DONE)
//   F3_*        : funct3 encodings of the divide-class instructions
//   f3_is_signed / f3_is_rem : decode helpers for funct3
package div_sequencer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   // funct3[0] clear selects the signed variants (DIV, REM).
   function automatic logic f3_is_signed(input logic [2:0] f3);
      return ~f3[0];
   endfunction

   // funct3[1] set selects the remainder variants (REM, REMU).
   function automatic logic f3_is_rem(input logic [2:0] f3);
      return f3[1];
   endfunction

endpackage

// File: rtl/div_restoring_step.sv
// One radix-2 restoring division iteration, purely combinational.
//   rem     : partial remainder (always < divisor)
//   quo     : dividend bits still to consume (MSB first) / quotient bits built so far (LSB)
//   divisor : divisor magnitude
//   rem_n   : next partial remainder
//   quo_n   : quo shifted left with the new quotient bit in the LSB
module div_restoring_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_n,
   output logic [XLEN-1:0] quo_n
);

   // The shifted remainder keeps rem's MSB so divisors with the top bit set still
   // divide correctly; one extra bit on the subtraction makes the borrow the sign.
   logic [XLEN:0]   shifted;
   logic [XLEN+1:0] trial;
   logic            borrow;
   logic            unused_trial_msb;

   assign shifted          = {rem, quo[XLEN-1]};
   assign trial            = {1'b0, shifted} - {2'b00, divisor};
   assign borrow           = trial[XLEN+1];
   assign unused_trial_msb = trial[XLEN];

   // When the trial succeeds it is < divisor, and when it fails shifted < divisor,
   // so either way the new remainder fits in XLEN bits.
   assign rem_n = borrow ? shifted[XLEN-1:0] : trial[XLEN-1:0];
   assign quo_n = {quo[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_sequencer.sv
// Iterative DIV/DIVU/REM/REMU controller for the EX stage.
//   clk, rst_n     : core clock, asynchronous active-low reset
//   start_EX       : divide-class instruction valid in EX
//   funct3_EX      : operation select (DIV, DIVU, REM, REMU)
//   rs1_val_EX     : dividend (forwarded)
//   rs2_val_EX     : divisor (forwarded)
//   flush_EX       : abort the current operation
//   stall_req      : hold F/DE/EX while the divide is in flight
//   busy           : sequencer not idle
//   result_valid   : one-cycle result strobe
//   result         : quotient or remainder, 0 when result_valid is low
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_EX,
   input  logic [2:0]      funct3_EX,
   input  logic [XLEN-1:0] rs1_val_EX,
   input  logic [XLEN-1:0] rs2_val_EX,
   input  logic            flush_EX,
   output logic            stall_req,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   localparam int unsigned CntW = $clog2(XLEN) + 1;

   localparam logic [XLEN-1:0] IntMin = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] AllOnes = {XLEN{1'b1}};

   div_state_t      state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] divisor_q, divisor_d;
   logic [XLEN-1:0] rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            sel_rem_q, sel_rem_d;

   // Operand decode in the issuing cycle.
   logic            op_signed;
   logic            sign1, sign2;
   logic [XLEN-1:0] mag1, mag2;
   logic            div_by_zero;
   logic            div_overflow;
   logic            issue;
   logic            unused_f3_msb;

   assign op_signed     = f3_is_signed(funct3_EX);
   assign sign1         = op_signed & rs1_val_EX[XLEN-1];
   assign sign2         = op_signed & rs2_val_EX[XLEN-1];
   assign mag1          = sign1 ? -rs1_val_EX : rs1_val_EX;
   assign mag2          = sign2 ? -rs2_val_EX : rs2_val_EX;
   assign div_by_zero   = (rs2_val_EX == '0);
   assign div_overflow  = op_signed & (rs1_val_EX == IntMin) & (rs2_val_EX == AllOnes);
   assign issue         = (state_q == IDLE) & start_EX & ~flush_EX;
   // funct3[2] is implied by start_EX (only divide-class ops assert it).
   assign unused_f3_msb = funct3_EX[2];

   logic [XLEN-1:0] step_rem, step_quo;

   div_restoring_step #(
      .XLEN (XLEN)
   ) u_step (
      .rem     (rem_q),
      .quo     (quo_q),
      .divisor (divisor_q),
      .rem_n   (step_rem),
      .quo_n   (step_quo)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      divisor_d = divisor_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      sel_rem_d = sel_rem_q;

      unique case (state_q)
         IDLE: begin
            if (issue) begin
               sel_rem_d = f3_is_rem(funct3_EX);
               if (div_by_zero) begin
                  // Architectural results are preloaded; sign fix-up is disabled.
                  quo_d     = AllOnes;
                  rem_d     = rs1_val_EX;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = DONE;
               end else if (div_overflow) begin
                  quo_d     = IntMin;
                  rem_d     = '0;
                  neg_quo_d = 1'b0;
                  neg_rem_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = DONE;
               end else begin
                  divisor_d = mag2;
                  quo_d     = mag1;
                  rem_d     = '0;
                  neg_quo_d = sign1 ^ sign2;
                  neg_rem_d = sign1;
                  cnt_d     = CntW'(XLEN);
                  state_d   = CALC;
               end
            end
         end
         CALC: begin
            if (flush_EX) begin
               state_d = IDLE;
            end else begin
               rem_d = step_rem;
               quo_d = step_quo;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CntW'(1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         divisor_q <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         sel_rem_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         divisor_q <= divisor_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         sel_rem_q <= sel_rem_d;
      end
   end

   // Issue-cycle stall is combinational on start_EX so the divide stays in EX.
   // rst_n gating keeps a held instruction from stalling the front end in reset.
   assign stall_req = rst_n & (issue | (state_q == CALC));
   assign busy      = (state_q != IDLE);

   logic [XLEN-1:0] quo_fixed, rem_fixed;

   assign quo_fixed    = neg_quo_q ? -quo_q : quo_q;
   assign rem_fixed    = neg_rem_q ? -rem_q : rem_q;
   assign result_valid = (state_q == DONE) & ~flush_EX;
   assign result       = result_valid ? (sel_rem_q ? rem_fixed : quo_fixed) : '0;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: the driver models the EX stage holding an
// instruction while stall_req is high and pushes the expected result and its
// arrival cycle; an independent monitor pops and compares on every result strobe.
module tb_div_sequencer;
   import div_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_EX = 1'b0;
   logic [2:0]  funct3_EX = 3'b000;
   logic [31:0] rs1_val_EX = '0;
   logic [31:0] rs2_val_EX = '0;
   logic        flush_EX = 1'b0;
   logic        stall_req;
   logic        busy;
   logic        result_valid;
   logic [31:0] result;

   div_sequencer #(
      .XLEN (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_EX     (start_EX),
      .funct3_EX    (funct3_EX),
      .rs1_val_EX   (rs1_val_EX),
      .rs2_val_EX   (rs2_val_EX),
      .flush_EX     (flush_EX),
      .stall_req    (stall_req),
      .busy         (busy),
      .result_valid (result_valid),
      .result       (result)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] val;
      int unsigned at;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int unsigned valid_pulses = 0;
   int unsigned last_valid_cyc = 0;
   int unsigned prev_valid_cyc = 0;

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // RISC-V M-extension semantics written directly from the ISA rules.
   function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      logic is_sgn;
      logic is_rem;
      int   sa;
      int   sb;
      is_sgn = ~f3[0];
      is_rem = f3[1];
      sa = $signed(a);
      sb = $signed(b);
      if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
      if (is_sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return is_rem ? 32'd0 : 32'h8000_0000;
      if (is_sgn) return is_rem ? 32'(sa % sb) : 32'(sa / sb);
      return is_rem ? a % b : a / b;
   endfunction

   function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (~f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Issue one instruction and hold it in EX until the stall releases it.
   task automatic run_instr(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input int lat);
      int   n;
      logic s;
      logic done;
      @(negedge clk);
      start_EX   = 1'b1;
      funct3_EX  = f3;
      rs1_val_EX = a;
      rs2_val_EX = b;
      sb_q.push_back('{val: exp, at: cyc + lat, name: name});
      n = 0;
      done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         #1;
         s = stall_req;
         if (s) n++;
         @(posedge clk);
         if (!s) done = 1'b1;
         else @(negedge clk);
      end
      check_int({name, "_retired"}, int'(done), 1);
      check_int({name, "_stall_cycles"}, n, lat);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         start_EX = 1'b0;
      end
   endtask

   // Monitor: samples between the driver's negedge updates and the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (result_valid) begin
               valid_pulses++;
               prev_valid_cyc = last_valid_cyc;
               last_valid_cyc = cyc;
               check_int("result_expected", int'(sb_q.size() > 0), 1);
               if (sb_q.size() > 0) begin
                  e = sb_q.pop_front();
                  check_val(e.name, result, e.val);
                  check_int({e.name, "_cycle"}, int'(cyc), int'(e.at));
               end
            end else begin
               check_val("result_zero_when_idle", result, 32'd0);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  f3;
      logic [31:0] a, b;
      int unsigned pulses_before;
      int unsigned kind;

      // Reset state.
      #1;
      check_val("rst_stall_req", {31'd0, stall_req}, 32'd0);
      check_val("rst_busy", {31'd0, busy}, 32'd0);
      check_val("rst_result_valid", {31'd0, result_valid}, 32'd0);
      check_val("rst_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(2);

      // Directed cases with hand-derived expectations.
      run_instr("divu_100_7", F3_DIVU, 32'd100, 32'd7, 32'd14, 33);
      run_instr("remu_100_7", F3_REMU, 32'd100, 32'd7, 32'd2, 33);
      run_instr("div_m7_2", F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run_instr("rem_m7_2", F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run_instr("divu_5_0", F3_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
      run_instr("remu_5_0", F3_REMU, 32'd5, 32'd0, 32'd5, 1);
      run_instr("div_ovf", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_instr("rem_ovf", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
      run_instr("divu_big_dvsr", F3_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33);
      idle_cycles(1);

      // Back-to-back issue: no bubble between the two instructions.
      run_instr("b2b_9_3", F3_DIVU, 32'd9, 32'd3, 32'd3, 33);
      run_instr("b2b_8_2", F3_DIVU, 32'd8, 32'd2, 32'd4, 33);
      check_int("b2b_spacing", int'(last_valid_cyc - prev_valid_cyc), 34);
      idle_cycles(2);

      // Flush during CALC: no result, back to idle the next cycle.
      pulses_before = valid_pulses;
      @(negedge clk);
      start_EX   = 1'b1;
      funct3_EX  = F3_DIVU;
      rs1_val_EX = 32'd1000;
      rs2_val_EX = 32'd3;
      repeat (10) @(negedge clk);
      flush_EX = 1'b1;
      #1;
      check_val("flush_busy_t10", {31'd0, busy}, 32'd1);
      check_val("flush_valid_t10", {31'd0, result_valid}, 32'd0);
      @(negedge clk);
      flush_EX = 1'b0;
      start_EX = 1'b0;
      #1;
      check_val("flush_busy_t11", {31'd0, busy}, 32'd0);
      check_val("flush_stall_t11", {31'd0, stall_req}, 32'd0);
      idle_cycles(40);
      check_int("flush_no_result", int'(valid_pulses), int'(pulses_before));

      // Asynchronous reset mid-operation with the instruction still held in EX.
      @(negedge clk);
      start_EX   = 1'b1;
      funct3_EX  = F3_DIV;
      rs1_val_EX = 32'd12345;
      rs2_val_EX = 32'd17;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("midrst_stall_req", {31'd0, stall_req}, 32'd0);
      check_val("midrst_busy", {31'd0, busy}, 32'd0);
      check_val("midrst_result_valid", {31'd0, result_valid}, 32'd0);
      check_val("midrst_result", result, 32'd0);
      start_EX = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles(2);
      check_int("midrst_no_result", int'(valid_pulses), int'(pulses_before));

      // Randomised operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         f3 = {1'b1, 2'($urandom_range(0, 3))};
         kind = $urandom_range(0, 9);
         a = $urandom();
         b = $urandom();
         case (kind)
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: b = b | 32'h8000_0000;
            4: a = $urandom_range(0, 255);
            default: ;
         endcase
         run_instr("rand", f3, a, b, ref_div(f3, a, b), ref_latency(f3, a, b));
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(5);
      check_int("scoreboard_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
